// File: rtl/video_cfg_pkg.sv
// Shared definitions for the video configuration sequencer.
// Register map, reset colours and controller state encoding.
package video_cfg_pkg;

  localparam logic [2:0] ADDR_PAT  = 3'd0;
  localparam logic [2:0] ADDR_FG   = 3'd1;
  localparam logic [2:0] ADDR_BG   = 3'd2;
  localparam logic [2:0] ADDR_X0   = 3'd3;
  localparam logic [2:0] ADDR_Y0   = 3'd4;
  localparam logic [2:0] ADDR_X1   = 3'd5;
  localparam logic [2:0] ADDR_Y1   = 3'd6;
  localparam logic [2:0] ADDR_AUTO = 3'd7;

  localparam logic [23:0] DEF_FG   = 24'hFFFFFF;
  localparam logic [23:0] DEF_BG   = 24'h0000FF;
  localparam logic [1:0]  DEF_PAT  = 2'd0;
  localparam logic [7:0]  DEF_AUTO = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Pattern select wraps 3 -> 0 naturally in two bits.
  function automatic logic [1:0] pat_next(
    input logic [1:0] p
  );
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/video_cfg_regfile.sv
// Shadow/active register pairs for the video configuration.
// Writes land in shadow; a commit copies every shadow to active at once.
module video_cfg_regfile
  import video_cfg_pkg::*;
#(
  parameter int WB         = 9,
  parameter int SW         = 720,
  parameter int SH         = 480,
  parameter int BOX_MARGIN = 100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [2:0]    i_waddr,
  input  logic [23:0]   i_wdata,
  input  logic          i_commit,
  input  logic          i_adv,
  output logic [1:0]    o_pat,
  output logic [23:0]   o_fg,
  output logic [23:0]   o_bg,
  output logic [WB:0]   o_x0,
  output logic [WB:0]   o_y0,
  output logic [WB:0]   o_x1,
  output logic [WB:0]   o_y1,
  output logic [7:0]    o_auto
);

  localparam int X1_I = SW - BOX_MARGIN;
  localparam int Y1_I = SH - BOX_MARGIN;
  localparam logic [WB:0] DEF_X0 = BOX_MARGIN[WB:0];
  localparam logic [WB:0] DEF_Y0 = BOX_MARGIN[WB:0];
  localparam logic [WB:0] DEF_X1 = X1_I[WB:0];
  localparam logic [WB:0] DEF_Y1 = Y1_I[WB:0];

  logic [1:0]  r_s_pat,  r_a_pat;
  logic [23:0] r_s_fg,   r_a_fg;
  logic [23:0] r_s_bg,   r_a_bg;
  logic [WB:0] r_s_x0,   r_a_x0;
  logic [WB:0] r_s_y0,   r_a_y0;
  logic [WB:0] r_s_x1,   r_a_x1;
  logic [WB:0] r_s_y1,   r_a_y1;
  logic [7:0]  r_s_auto, r_a_auto;

  logic [1:0]  w_pat_adv;

  assign w_pat_adv = pat_next(r_a_pat);

  // Shadow bank: host writes, plus auto-advance keeps PAT_SEL in step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_pat  <= DEF_PAT;
      r_s_fg   <= DEF_FG;
      r_s_bg   <= DEF_BG;
      r_s_x0   <= DEF_X0;
      r_s_y0   <= DEF_Y0;
      r_s_x1   <= DEF_X1;
      r_s_y1   <= DEF_Y1;
      r_s_auto <= DEF_AUTO;
    end else begin
      if (i_adv) begin
        r_s_pat <= w_pat_adv;
      end
      if (i_we) begin
        unique case (i_waddr)
          ADDR_PAT:  r_s_pat  <= i_wdata[1:0];
          ADDR_FG:   r_s_fg   <= i_wdata;
          ADDR_BG:   r_s_bg   <= i_wdata;
          ADDR_X0:   r_s_x0   <= i_wdata[WB:0];
          ADDR_Y0:   r_s_y0   <= i_wdata[WB:0];
          ADDR_X1:   r_s_x1   <= i_wdata[WB:0];
          ADDR_Y1:   r_s_y1   <= i_wdata[WB:0];
          ADDR_AUTO: r_s_auto <= i_wdata[7:0];
          default:   r_s_pat  <= r_s_pat;
        endcase
      end
    end
  end

  // Active bank: whole-set copy on commit, else pattern auto-advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_pat  <= DEF_PAT;
      r_a_fg   <= DEF_FG;
      r_a_bg   <= DEF_BG;
      r_a_x0   <= DEF_X0;
      r_a_y0   <= DEF_Y0;
      r_a_x1   <= DEF_X1;
      r_a_y1   <= DEF_Y1;
      r_a_auto <= DEF_AUTO;
    end else if (i_commit) begin
      r_a_pat  <= r_s_pat;
      r_a_fg   <= r_s_fg;
      r_a_bg   <= r_s_bg;
      r_a_x0   <= r_s_x0;
      r_a_y0   <= r_s_y0;
      r_a_x1   <= r_s_x1;
      r_a_y1   <= r_s_y1;
      r_a_auto <= r_s_auto;
    end else if (i_adv) begin
      r_a_pat  <= w_pat_adv;
    end
  end

  assign o_pat  = r_a_pat;
  assign o_fg   = r_a_fg;
  assign o_bg   = r_a_bg;
  assign o_x0   = r_a_x0;
  assign o_y0   = r_a_y0;
  assign o_x1   = r_a_x1;
  assign o_y1   = r_a_y1;
  assign o_auto = r_a_auto;

endmodule

// File: rtl/video_cfg_sequencer.sv
// Video configuration sequencer: command port, vblank commit FSM,
// frame boundary detect and pattern auto-cycle counter.
module video_cfg_sequencer
  import video_cfg_pkg::*;
#(
  parameter int WB         = 9,
  parameter int SW         = 720,
  parameter int SH         = 480,
  parameter int BOX_MARGIN = 100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WB:0]   sx,
  input  logic [WB:0]   sy,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_addr,
  input  logic [23:0]   cmd_data,
  output logic [1:0]    pat_sel,
  output logic [23:0]   fg_rgb,
  output logic [23:0]   bg_rgb,
  output logic [WB:0]   box_x0,
  output logic [WB:0]   box_y0,
  output logic [WB:0]   box_x1,
  output logic [WB:0]   box_y1,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam logic [WB:0] SH_L = SH[WB:0];

  state_t      r_state;
  state_t      w_next;
  logic        r_ready;
  logic [7:0]  r_cnt;
  logic        w_fs;
  logic        w_acc;
  logic        w_commit;
  logic        w_eval;
  logic        w_adv;
  logic [7:0]  w_cnt_inc;
  logic [7:0]  w_auto;

  assign w_fs      = (sx == '0) && (sy == SH_L);
  assign w_acc     = cmd_valid && r_ready;
  assign w_commit  = (r_state == ST_COMMIT);
  assign w_cnt_inc = r_cnt + 8'd1;

  // Auto-cycle runs on a boundary only when no commit is taking it over.
  assign w_eval = w_fs && !w_commit && (w_next != ST_COMMIT);
  assign w_adv  = w_eval && (w_auto != 8'd0) && (w_cnt_inc == w_auto);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: a dirty shadow (or a write on the boundary) commits.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc && w_fs) begin
          w_next = ST_COMMIT;
        end else if (w_acc) begin
          w_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_fs) begin
          w_next = ST_COMMIT;
        end
      end
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Ready is registered; it drops only for the commit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b1;
    end else begin
      r_ready <= (w_next != ST_COMMIT);
    end
  end

  // Frame counter for auto-cycle; any commit restarts it from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (w_fs && !w_commit) begin
      if (!w_eval || w_auto == 8'd0 || w_adv) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  video_cfg_regfile #(
    .WB         (WB),
    .SW         (SW),
    .SH         (SH),
    .BOX_MARGIN (BOX_MARGIN)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_acc),
    .i_waddr  (cmd_addr),
    .i_wdata  (cmd_data),
    .i_commit (w_commit),
    .i_adv    (w_adv),
    .o_pat    (pat_sel),
    .o_fg     (fg_rgb),
    .o_bg     (bg_rgb),
    .o_x0     (box_x0),
    .o_y0     (box_y0),
    .o_x1     (box_x1),
    .o_y1     (box_y1),
    .o_auto   (w_auto)
  );

  assign cmd_ready   = r_ready;
  assign frame_start = w_fs;
  assign frame_cnt   = r_cnt;

endmodule

// File: tb/tb_video_cfg_sequencer.sv
// Testbench for video_cfg_sequencer: directed scenarios plus random
// command traffic, checked every cycle against a frame-level model.
module tb_video_cfg_sequencer;

  localparam int WB = 9;
  localparam int SW = 720;
  localparam int SH = 480;
  localparam int BM = 100;
  localparam int HT = 4;
  localparam int VT = 484;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic [WB:0] sx, sy;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_addr;
  logic [23:0] cmd_data;
  logic [1:0]  pat_sel;
  logic [23:0] fg_rgb, bg_rgb;
  logic [WB:0] box_x0, box_y0, box_x1, box_y1;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int pos      = 0;
  int fs_seen  = 0;

  always #5 clk = ~clk;

  video_cfg_sequencer #(
    .WB(WB), .SW(SW), .SH(SH), .BOX_MARGIN(BM)
  ) dut (
    .clk(clk), .rst(rst), .sx(sx), .sy(sy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .pat_sel(pat_sel), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .box_x0(box_x0), .box_y0(box_y0),
    .box_x1(box_x1), .box_y1(box_y1),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  // Simplified raster: HT columns per line, VT lines per frame.
  initial begin
    sx = '0;
    sy = '0;
    forever begin
      @(posedge clk);
      #1;
      pos = (pos + 1) % FRAME;
      sx = 10'(pos % HT);
      sy = 10'(pos / HT);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h t=%0t",
                 name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] m_sh  [8];
  logic [23:0] m_act [8];
  bit m_dirty, m_cnow, m_init, m_fs;
  int m_cnt;

  function automatic logic [23:0] trunc(input int a,
                                        input logic [23:0] d);
    case (a)
      0:       return d & 24'h3;
      1, 2:    return d;
      7:       return d & 24'hFF;
      default: return d & 24'h3FF;
    endcase
  endfunction

  task automatic m_reset();
    m_act[0] = 0;
    m_act[1] = 24'hFFFFFF;
    m_act[2] = 24'h0000FF;
    m_act[3] = BM;
    m_act[4] = BM;
    m_act[5] = SW - BM;
    m_act[6] = SH - BM;
    m_act[7] = 0;
    for (int i = 0; i < 8; i++) m_sh[i] = m_act[i];
    m_dirty = 0;
    m_cnow  = 0;
    m_cnt   = 0;
  endtask

  initial m_init = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_reset();
      m_init = 1;
    end else if (m_init) begin
      if (m_cnow) begin
        for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
        m_cnow = 0;
      end else begin
        m_fs = (pos == SH * HT);
        if (cmd_valid) begin
          m_sh[cmd_addr] = trunc(int'(cmd_addr), cmd_data);
          m_dirty = 1;
        end
        if (m_fs && m_dirty) begin
          m_cnow  = 1;
          m_dirty = 0;
          m_cnt   = 0;
        end else if (m_fs) begin
          if (m_act[7] == 0) begin
            m_cnt = 0;
          end else if (m_cnt + 1 == int'(m_act[7])) begin
            m_act[0] = (m_act[0] + 1) & 24'h3;
            m_sh[0]  = m_act[0];
            m_cnt    = 0;
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("pat_sel",     32'(pat_sel),     32'(m_act[0]));
      chk("fg_rgb",      32'(fg_rgb),      32'(m_act[1]));
      chk("bg_rgb",      32'(bg_rgb),      32'(m_act[2]));
      chk("box_x0",      32'(box_x0),      32'(m_act[3]));
      chk("box_y0",      32'(box_y0),      32'(m_act[4]));
      chk("box_x1",      32'(box_x1),      32'(m_act[5]));
      chk("box_y1",      32'(box_y1),      32'(m_act[6]));
      chk("frame_cnt",   32'(frame_cnt),   32'(m_cnt));
      chk("cmd_ready",   32'(cmd_ready),   32'(!m_cnow));
      chk("frame_start", 32'(frame_start), 32'(pos == SH * HT));
    end
    if (frame_start === 1'b1) fs_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_pos(input int x, input int y);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(sx) == x && int'(sy) == y) && n < 3 * FRAME);
    if (!(int'(sx) == x && int'(sy) == y)) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_pos timeout: at %0d,%0d wanted %0d,%0d",
               sx, sy, x, y);
    end
  endtask

  task automatic write_now(input int a, input logic [23:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = 3'(a);
    cmd_data  = d;
    while (!cmd_ready && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("write_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  int exp_pat [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int exp_cnt [12] = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0};

  initial begin
    int fs0;
    int mode;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset defaults.
    chk("rst_pat",  32'(pat_sel),   32'd0);
    chk("rst_fg",   32'(fg_rgb),    32'hFFFFFF);
    chk("rst_bg",   32'(bg_rgb),    32'h0000FF);
    chk("rst_x0",   32'(box_x0),    32'd100);
    chk("rst_y0",   32'(box_y0),    32'd100);
    chk("rst_x1",   32'(box_x1),    32'd620);
    chk("rst_y1",   32'(box_y1),    32'd380);
    chk("rst_cnt",  32'(frame_cnt), 32'd0);
    chk("rst_rdy",  32'(cmd_ready), 32'd1);

    // Two idle frames: exactly two boundary pulses.
    fs0 = fs_seen;
    repeat (2 * FRAME) @(negedge clk);
    chk("fs_per_2frames", 32'(fs_seen - fs0), 32'd2);
    chk("idle_pat", 32'(pat_sel), 32'd0);

    // Pattern write commits two cycles after the boundary.
    wait_pos(0, 200);
    write_now(0, 24'd2);
    wait_pos(0, SH);
    chk("pat_T",     32'(pat_sel),   32'd0);
    chk("rdy_T",     32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("pat_T1",    32'(pat_sel),   32'd0);
    chk("rdy_T1",    32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("pat_T2",    32'(pat_sel),   32'd2);
    chk("rdy_T2",    32'(cmd_ready), 32'd1);

    // Two box corners switch together.
    wait_pos(0, 100);
    write_now(3, 24'd50);
    write_now(5, 24'd300);
    wait_pos(0, SH);
    @(negedge clk);
    chk("x0_T1", 32'(box_x0), 32'd100);
    chk("x1_T1", 32'(box_x1), 32'd620);
    @(negedge clk);
    chk("x0_T2", 32'(box_x0), 32'd50);
    chk("x1_T2", 32'(box_x1), 32'd300);

    // Write in the boundary cycle itself is included.
    wait_pos(0, SH);
    write_now(1, 24'h00FF00);
    chk("fg_T1", 32'(fg_rgb), 32'hFFFFFF);
    @(negedge clk);
    chk("fg_T2", 32'(fg_rgb), 32'h00FF00);

    // Auto-cycle every 3 frames.
    wait_pos(0, 100);
    write_now(0, 24'd0);
    write_now(7, 24'd3);
    wait_pos(0, SH);
    repeat (2) @(negedge clk);
    chk("auto_pat0", 32'(pat_sel),   32'd0);
    chk("auto_cnt0", 32'(frame_cnt), 32'd0);
    for (int k = 0; k < 12; k++) begin
      wait_pos(0, SH);
      repeat (2) @(negedge clk);
      chk("auto_pat", 32'(pat_sel),   32'(exp_pat[k]));
      chk("auto_cnt", 32'(frame_cnt), 32'(exp_cnt[k]));
    end
    wait_pos(0, SH);
    wait_pos(0, SH);
    // Written pattern wins over an advance on the same boundary.
    wait_pos(0, 100);
    write_now(0, 24'd3);
    wait_pos(0, SH);
    repeat (2) @(negedge clk);
    chk("ovr_pat", 32'(pat_sel),   32'd3);
    chk("ovr_cnt", 32'(frame_cnt), 32'd0);
    wait_pos(0, SH);
    repeat (2) @(negedge clk);
    chk("ovr_pat1", 32'(pat_sel),   32'd3);
    chk("ovr_cnt1", 32'(frame_cnt), 32'd1);

    // Reset discards a pending write.
    wait_pos(0, 200);
    write_now(2, 24'h123456);
    wait_pos(0, 300);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_pos(0, SH);
    chk("rr_rdy_T",  32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("rr_rdy_T1", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("rr_bg",     32'(bg_rgb),    32'h0000FF);
    chk("rr_pat",    32'(pat_sel),   32'd0);

    // Random traffic, with extra weight on the boundary cycle.
    for (int f = 0; f < 12; f++) begin
      mode = int'($urandom % 3);
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        rst = ($urandom % 4000) == 0;
        case (mode)
          0:       cmd_valid = 1'b0;
          1:       cmd_valid = ($urandom % 400) == 0;
          default: cmd_valid = ($urandom % 4) == 0;
        endcase
        if (mode != 0 && frame_start && ($urandom % 2) == 0)
          cmd_valid = 1'b1;
        cmd_addr = 3'($urandom % 8);
        if (cmd_addr == 3'd7)
          cmd_data = 24'($urandom % 4);
        else
          cmd_data = 24'($urandom);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
